// File: rtl/axim_arb_pkg.sv
// Shared types and the round-robin pick helper for the AXIM channel arbiters.
package axim_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} arb_state_t;

    localparam int MAX_REQ = 8;

    // One-hot grant: first set bit of req at or after ptr, wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input logic [2:0]         ptr,
                                                  input logic [3:0]         n);
        logic [MAX_REQ-1:0] grant;
        logic [3:0]         idx;
        grant = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= n) idx = idx - n;
            if ((4'(k) < n) && (grant == '0) && req[idx[2:0]]) grant[idx[2:0]] = 1'b1;
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant from a request vector and a priority pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_vld
);
    import axim_arb_pkg::*;

    assign grant     = NUM_REQ'(rr_pick(MAX_REQ'(req), 3'(ptr), 4'(NUM_REQ)));
    assign grant_vld = |req;

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
    end

endmodule

// File: rtl/axim_rd_arbiter.sv
// Round-robin sharing of one AXIM read control interface and its read stream
// between NUM_REQ requesters; one transfer in flight at a time.
module axim_rd_arbiter #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int NUM_REQ            = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQ-1:0]                      req_valid_i,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   req_raddr_i,
    input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0]    req_xfer_size_i,
    output logic [NUM_REQ-1:0]                      req_ack_o,
    output logic [NUM_REQ-1:0]                      req_done_o,
    output logic [C_M_AXI_DATA_WIDTH-1:0]           req_tdata_o,
    output logic [NUM_REQ-1:0]                      req_tvalid_o,
    input  logic [NUM_REQ-1:0]                      req_tready_i,
    output logic                                    req_tlast_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]           ctrl_raddr_offset_o,
    output logic [C_XFER_SIZE_WIDTH-1:0]            ctrl_rxfer_size_o,
    output logic                                    ctrl_rstart_o,
    input  logic                                    ctrl_rdone_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]           rd_tdata_i,
    input  logic                                    rd_tvalid_i,
    output logic                                    rd_tready_o,
    input  logic                                    rd_tlast_i
);
    import axim_arb_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t                     state;
    logic [PTR_W-1:0]               rr_ptr;
    logic [PTR_W-1:0]               owner;
    logic                           done_seen;
    logic                           last_seen;

    logic [NUM_REQ-1:0]             grant;
    logic [PTR_W-1:0]               grant_idx;
    logic                           grant_vld;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  sel_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]   sel_size;
    logic [NUM_REQ-1:0]             owner_oh;
    logic                           busy;
    logic                           done_now;
    logic                           last_now;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req       (req_valid_i),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign sel_addr = req_raddr_i[grant_idx*C_M_AXI_ADDR_WIDTH +: C_M_AXI_ADDR_WIDTH];
    assign sel_size = req_xfer_size_i[grant_idx*C_XFER_SIZE_WIDTH +: C_XFER_SIZE_WIDTH];
    assign owner_oh = NUM_REQ'(1) << owner;
    assign busy     = (state == BUSY);

    // Stream routing: only the owner sees the AXIM read stream, and only in BUSY.
    assign rd_tready_o  = busy & req_tready_i[owner];
    assign req_tvalid_o = busy ? (owner_oh & {NUM_REQ{rd_tvalid_i}}) : '0;
    assign req_tdata_o  = busy ? rd_tdata_i : '0;
    assign req_tlast_o  = busy & rd_tlast_i;

    assign done_now = done_seen | ctrl_rdone_i;
    assign last_now = last_seen | (rd_tvalid_i & rd_tready_o & rd_tlast_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            owner               <= '0;
            done_seen           <= 1'b0;
            last_seen           <= 1'b0;
            req_ack_o           <= '0;
            req_done_o          <= '0;
            ctrl_rstart_o       <= 1'b0;
            ctrl_raddr_offset_o <= '0;
            ctrl_rxfer_size_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner               <= grant_idx;
                        ctrl_raddr_offset_o <= sel_addr;
                        ctrl_rxfer_size_o   <= sel_size;
                        req_ack_o           <= grant;
                        // Nothing to move: skip AXIM and acknowledge together with done.
                        if (sel_size == '0) begin
                            req_done_o <= grant;
                            state      <= DONE;
                        end else begin
                            ctrl_rstart_o <= 1'b1;
                            state         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    ctrl_rstart_o <= 1'b0;
                    req_ack_o     <= '0;
                    state         <= BUSY;
                end
                BUSY: begin
                    done_seen <= done_now;
                    last_seen <= last_now;
                    if (done_now && last_now) begin
                        req_done_o <= owner_oh;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    req_ack_o  <= '0;
                    req_done_o <= '0;
                    done_seen  <= 1'b0;
                    last_seen  <= 1'b0;
                    rr_ptr     <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
